// File: rtl/coin_arbiter.sv
// Shares one vending credit FSM between two coin slots: round-robin coin
// acceptance, one settle cycle per coin, and a timed dispenser handshake.
module coin_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] s0_coin,
  input  logic       s0_valid,
  output logic       s0_ready,
  input  logic [1:0] s1_coin,
  input  logic       s1_valid,
  output logic       s1_ready,
  output logic [1:0] coin,
  input  logic       drop,
  output logic       dispense_req,
  input  logic       dispense_ack,
  output logic [7:0] vend_count,
  output logic       fault
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SETTLE   = 2'd1;
  localparam logic [1:0] DISPENSE = 2'd2;
  localparam logic [7:0] LOAD     = 8'(TIMEOUT - 1);

  logic [1:0] state_reg, state_next;
  logic       rr_reg, rr_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       req_reg, req_next;
  logic [7:0] vend_reg, vend_next;
  logic       fault_reg, fault_next;
  logic       gnt0, gnt1;

  // Grants are combinational and suppressed while reset is held low.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset && (state_reg == IDLE)) begin
      gnt0 = s0_valid && (!s1_valid || !rr_reg);
      gnt1 = s1_valid && (!s0_valid ||  rr_reg);
    end
  end

  assign s0_ready     = gnt0;
  assign s1_ready     = gnt1;
  assign coin         = gnt0 ? s0_coin : (gnt1 ? s1_coin : 2'b00);
  assign dispense_req = req_reg;
  assign vend_count   = vend_reg;
  assign fault        = fault_reg;

  always_comb begin
    state_next = state_reg;
    rr_next    = rr_reg;
    cnt_next   = cnt_reg;
    req_next   = req_reg;
    vend_next  = vend_reg;
    fault_next = fault_reg;
    case (state_reg)
      IDLE: begin
        req_next = 1'b0;
        if (gnt0 || gnt1) begin
          rr_next = gnt0;
          // A zero coin is swallowed here and never needs a settle cycle.
          if (coin != 2'b00) begin
            state_next = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (drop) begin
          state_next = DISPENSE;
          req_next   = 1'b1;
          cnt_next   = LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      DISPENSE: begin
        // Ack takes priority over an expiring counter.
        if (dispense_ack) begin
          vend_next  = vend_reg + 8'd1;
          req_next   = 1'b0;
          state_next = IDLE;
        end else if (cnt_reg == 8'd0) begin
          fault_next = 1'b1;
          req_next   = 1'b0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= IDLE;
      rr_reg    <= 1'b0;
      cnt_reg   <= 8'd0;
      req_reg   <= 1'b0;
      vend_reg  <= 8'd0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      rr_reg    <= rr_next;
      cnt_reg   <= cnt_next;
      req_reg   <= req_next;
      vend_reg  <= vend_next;
      fault_reg <= fault_next;
    end
  end

endmodule

// File: tb/tb_coin_arbiter.sv
// Bench for coin_arbiter: per-cycle vector table plus directed sequences, with a
// credit FSM stand-in (price 4) and a scoreboard of expected coin accepts.
module tb_coin_arbiter;

  localparam int T = 6;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] s0_coin, s1_coin, coin;
  logic       s0_valid, s1_valid, s0_ready, s1_ready;
  logic       drop, dispense_req, dispense_ack, fault;
  logic [7:0] vend_count;

  int vectors = 0;
  int miscompares = 0;

  coin_arbiter #(.TIMEOUT(T)) dut (
    .clock(clock), .reset(reset),
    .s0_coin(s0_coin), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s1_coin(s1_coin), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .coin(coin), .drop(drop),
    .dispense_req(dispense_req), .dispense_ack(dispense_ack),
    .vend_count(vend_count), .fault(fault)
  );

  always #5 clock = ~clock;

  // Credit FSM stand-in: vends at credit >= 4, then clears.
  logic [3:0] credit;
  assign drop = (credit >= 4'd4);
  always @(posedge clock) begin
    if (!reset)    credit <= 4'd0;
    else if (drop) credit <= 4'd0;
    else           credit <= credit + {2'b00, coin};
  end

  typedef struct {
    logic       rst;
    logic       s0v;
    logic [1:0] s0c;
    logic       s1v;
    logic [1:0] s1c;
    logic       ack;
    logic       r0;
    logic       r1;
    logic [1:0] c;
    logic       req;
    logic [7:0] vend;
    logic       flt;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic s0v, input logic [1:0] s0c,
                              input logic s1v, input logic [1:0] s1c, input logic ack,
                              input logic r0, input logic r1, input logic [1:0] c,
                              input logic req, input logic [7:0] vend, input logic flt);
    vec_t v;
    v.rst = rst; v.s0v = s0v; v.s0c = s0c; v.s1v = s1v; v.s1c = s1c; v.ack = ack;
    v.r0 = r0; v.r1 = r1; v.c = c; v.req = req; v.vend = vend; v.flt = flt;
    return v;
  endfunction

  logic [2:0] sb[$];
  logic [2:0] sb_got, sb_exp;

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s step %0d: got %0d, want %0d", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    reset        = v.rst;
    s0_valid     = v.s0v;
    s0_coin      = v.s0c;
    s1_valid     = v.s1v;
    s1_coin      = v.s1c;
    dispense_ack = v.ack;
    if (v.r0) sb.push_back({1'b0, v.s0c});
    if (v.r1) sb.push_back({1'b1, v.s1c});
    #1;
    chk("s0_ready", idx, {7'd0, s0_ready}, {7'd0, v.r0});
    chk("s1_ready", idx, {7'd0, s1_ready}, {7'd0, v.r1});
    chk("coin", idx, {6'd0, coin}, {6'd0, v.c});
    chk("dispense_req", idx, {7'd0, dispense_req}, {7'd0, v.req});
    chk("vend_count", idx, vend_count, v.vend);
    chk("fault", idx, {7'd0, fault}, {7'd0, v.flt});
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: each observed handshake must match the oldest expected accept.
  always @(negedge clock) begin
    if ((s0_valid && s0_ready) || (s1_valid && s1_ready)) begin
      sb_got = {s1_ready, coin};
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL accept: got slot %0d coin %0d, want no accept", sb_got[2], sb_got[1:0]);
      end else begin
        sb_exp = sb.pop_front();
        if (sb_got !== sb_exp) begin
          miscompares++;
          $display("FAIL accept: got slot %0d coin %0d, want slot %0d coin %0d",
                   sb_got[2], sb_got[1:0], sb_exp[2], sb_exp[1:0]);
        end else begin
          $display("accept slot %0d coin %0d at %0t", sb_got[2], sb_got[1:0], $time);
        end
      end
    end
  end

  vec_t tbl[24];
  logic [7:0] ev;

  initial begin
    reset = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
    s0_coin = 2'b00; s1_coin = 2'b00; dispense_ack = 1'b0;

    // Round-robin, ack before timeout, zero coin, tie after a vend, timeout.
    for (int i = 0; i < 7; i++)
      tbl[i] = mk(1, 1, 1, 1, 1, 0, (i % 4 == 0), (i % 4 == 2), (i % 2 == 0) ? 2'd1 : 2'd0, 0, 0, 0);
    tbl[7]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[9]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[10] = mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    tbl[11] = mk(1, 1, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0);
    tbl[12] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[13] = mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    tbl[14] = mk(1, 1, 2, 1, 3, 0, 0, 1, 3, 0, 1, 0);
    tbl[15] = mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 16; i < 22; i++)
      tbl[i] = mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[22] = mk(1, 1, 2, 0, 0, 0, 1, 0, 2, 0, 1, 1);
    tbl[23] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++)
      apply(mk(0, 1, 3, 1, 3, 0, 0, 0, 0, 0, 0, 0), 900 + i);

    for (int i = 0; i < 24; i++)
      apply(tbl[i], i);

    // Vend after a fault still counts; fault stays set.
    apply(mk(1, 1, 1, 0, 0, 0, 1, 0, 1, 0, 1, 1), 100);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 101);
    apply(mk(1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 1), 102);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 103);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), 104);
    apply(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1), 105);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1), 106);

    // Reset in the middle of a dispense.
    apply(mk(1, 1, 3, 0, 0, 0, 1, 0, 3, 0, 2, 1), 200);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1), 201);
    apply(mk(1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 2, 1), 202);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1), 203);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1), 204);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1), 205);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 206);

    // Ack on the final timeout cycle; slot held off during dispense, accepted right after.
    apply(mk(1, 1, 3, 0, 0, 0, 1, 0, 3, 0, 0, 0), 300);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 301);
    apply(mk(1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0), 302);
    apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 303);
    for (int i = 0; i < T - 1; i++)
      apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 304 + i);
    apply(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0), 320);
    apply(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0), 321);
    apply(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0), 322);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 323);

    // 255 quick vends take vend_count from 1 through 255 and wrap to 0.
    ev = 8'd1;
    for (int k = 0; k < 255; k++) begin
      apply(mk(1, 1, 3, 0, 0, 0, 1, 0, 3, 0, ev, 0), 1000 + k);
      apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev, 0), 1000 + k);
      apply(mk(1, 1, 1, 0, 0, 0, 1, 0, 1, 0, ev, 0), 1000 + k);
      apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev, 0), 1000 + k);
      apply(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, ev, 0), 1000 + k);
      ev = ev + 8'd1;
    end
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev, 0), 2000);
    chk("vend_wrap", 2001, vend_count, 8'd0);
    chk("sb_leftover", 2002, 8'(sb.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
